key_mode_ctrl: RTL and testbench
================================

KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 3: consecutive stable synchronized samples required to accept a key level change (legal range 2..255).
REQ-002 Parameter LONG_CYCLES, default 10: debounced-pressed cycles that qualify a long press (legal range DB_CYCLES+1..65535).
REQ-003 Port clk  input  1: single clock; all logic on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port key_in  input  1: raw asynchronous key, active-low (0 = pressed, idle = 1).
REQ-006 Port en  input  1: event enable; 0 = mode and event pulses frozen, debouncer keeps running.
REQ-007 Port mode  output  2: current mode, registered.
REQ-008 Port press_short  output  1: one-cycle pulse on a qualified short press.
REQ-009 Port press_long  output  1: one-cycle pulse on a qualified long press.
REQ-010 Port key_level  output  1: debounced key level, active-low, registered.

Function
REQ-011 key_in SHALL pass through a two-flop synchronizer (both flops reset to 1) before any use.
REQ-012 Debounce: counter increments while synchronized level != key_level; resets to 0 when they match; when it reaches DB_CYCLES-1 with a mismatch still present, key_level takes the synchronized level and the counter clears.
REQ-013 Pulses of fewer than DB_CYCLES consecutive samples SHALL never change key_level.
REQ-014 Event FSM states: IDLE (key_level=1), HELD (pressed, long not yet fired), LONG (long fired, awaiting release).
REQ-015 IDLE->HELD on key_level falling; hold counter cleared to 0.
REQ-016 HELD: hold counter increments each cycle; at LONG_CYCLES-1 -> LONG, press_long=1 for that one cycle.
REQ-017 HELD->IDLE on key_level rising before long qualifies; press_short=1 for that one cycle.
REQ-018 LONG->IDLE on key_level rising; no pulse.
REQ-019 press_short SHALL advance mode by 1 modulo 4 (3->0 wraps); press_long SHALL load mode=0; mode updates in the same cycle the pulse is high.
REQ-020 en=0: FSM still tracks the key, but press_short/press_long are forced to 0 and mode holds; an event whose qualifying cycle falls while en=0 is lost, not deferred.
REQ-021 press_short and press_long SHALL never be high in the same cycle; at most one event per press.
REQ-022 Latency: key_level follows a stable key_in change after 2 (sync) + DB_CYCLES cycles; pulses one cycle after the key_level edge.

Reset
REQ-023 rst=1 SHALL force mode=0, press_short=0, press_long=0, key_level=1, FSM=IDLE, all counters 0, synchronizer flops 1.
REQ-024 Reset asserted mid-press SHALL discard the press; after release of rst with key_in still low, a new press SHALL be qualified from scratch.

Configuration
REQ-025 Macro KEY_LONG_PRESS_EN: defined -> long-press logic (LONG state, hold counter, press_long) present per REQ-014..018.
REQ-026 Undefined -> no hold counter or LONG state; every release from HELD gives press_short regardless of hold duration; press_long tied to 0; LONG_CYCLES unused.

Structure
REQ-027 Shared package key_ctrl_pkg SHALL hold the FSM state typedef (IDLE/HELD/LONG), the mode width constant (2), and MODE_RESET (2'd0).
REQ-028 Synchronizer plus debouncer SHALL be a sub-module key_debounce (ports clk, rst, key_in, key_level; parameter DB_CYCLES); the FSM, hold counter and mode register stay in key_mode_ctrl.

Verification (DB_CYCLES=3, LONG_CYCLES=10)
REQ-029 rst=1 for 3 cycles with key_in=0 -> mode=0, key_level=1, no pulses during or 2 cycles after reset.
REQ-030 key_in low 1 cycle and low 2 cycles (separated by 10 idle cycles) -> key_level stays 1, no pulses, mode unchanged.
REQ-031 Four presses, each low 6 cycles then high 10 -> press_short exactly once per press, mode 1,2,3,0 (wrap checked).
REQ-032 Mode=2, key_in low 20 cycles -> press_long once 10 cycles after key_level falls, mode=0, no press_short on release.
REQ-033 en=0 through a 6-cycle press -> no pulse, mode held; rst pulsed 1 cycle mid-press -> mode=0, no pulse on release.
REQ-034 Build without KEY_LONG_PRESS_EN, key_in low 20 cycles -> press_long never set, press_short once on release, mode increments by 1.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared types and constants for the key mode controller.
package key_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LONG = 2'd2
    } key_state_e;

    localparam int MODE_W = 2;
    localparam logic [MODE_W-1:0] MODE_RESET = 2'd0;

    function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] m);
        return m + MODE_W'(1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer followed by a stable-sample debouncer; key_level is active-low.
module key_debounce #(
    parameter int DB_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level
);

    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = 8'd0;
        if (sync2_q != level_q) begin
            if (cnt_q == DB_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign key_level = level_q;

endmodule

// File: rtl/key_mode_ctrl.sv
// Key press classifier and 2-bit mode register.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_mode_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES   = 3,
    parameter int LONG_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    input  logic              en,
    output logic [MODE_W-1:0] mode,
    output logic              press_short,
    output logic              press_long,
    output logic              key_level
);

    logic              lvl;
    key_state_e        state_q;
    logic [MODE_W-1:0] mode_q;
    logic              short_q;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (lvl)
    );

`ifdef KEY_LONG_PRESS_EN
    // Hold counter starts at 0 on HELD entry, so the long pulse lands LONG_CYCLES after key_level falls.
    localparam logic [15:0] HOLD_LAST = 16'(LONG_CYCLES - 2);

    logic [15:0] hold_q;
    logic        long_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= 16'd0;
            mode_q  <= MODE_RESET;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    hold_q <= 16'd0;
                    if (!lvl) state_q <= HELD;
                end
                HELD: begin
                    if (lvl) begin
                        state_q <= IDLE;
                        short_q <= en;
                        if (en) mode_q <= mode_next(mode_q);
                    end else if (hold_q == HOLD_LAST) begin
                        state_q <= LONG;
                        long_q  <= en;
                        if (en) mode_q <= MODE_RESET;
                    end else begin
                        hold_q <= hold_q + 16'd1;
                    end
                end
                LONG: begin
                    if (lvl) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign press_long = long_q;
`else
    logic unused_long_cycles;
    assign unused_long_cycles = (LONG_CYCLES > 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_RESET;
            short_q <= 1'b0;
        end else begin
            short_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!lvl) state_q <= HELD;
                end
                HELD: begin
                    if (lvl) begin
                        state_q <= IDLE;
                        short_q <= en;
                        if (en) mode_q <= mode_next(mode_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign press_long = 1'b0;
`endif

    assign mode        = mode_q;
    assign press_short = short_q;
    assign key_level   = lvl;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with DB_CYCLES=3, LONG_CYCLES=10; follows KEY_LONG_PRESS_EN.
module tb_key_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst, key_in, en;
    logic [1:0] mode;
    logic       press_short, press_long, key_level;

    int checks = 0, failures = 0;
    int cyc = 0, short_cnt = 0, long_cnt = 0, both_cnt = 0;
    int short_cyc = -1, long_cyc = -1, start;
    logic lvl_low = 1'b0;
    logic [1:0] exp_mode;

    key_mode_ctrl #(.DB_CYCLES(3), .LONG_CYCLES(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .en          (en),
        .mode        (mode),
        .press_short (press_short),
        .press_long  (press_long),
        .key_level   (key_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (press_short === 1'b1) begin short_cnt++; short_cyc = cyc; end
        if (press_long === 1'b1) begin long_cnt++; long_cyc = cyc; end
        if (press_short === 1'b1 && press_long === 1'b1) both_cnt++;
        if (key_level === 1'b0) lvl_low = 1'b1;
    endtask

    task automatic clr();
        short_cnt = 0; long_cnt = 0; short_cyc = -1; long_cyc = -1; lvl_low = 1'b0;
    endtask

    task automatic press(input int low, input int high);
        key_in = 1'b0;
        repeat (low) tick();
        key_in = 1'b1;
        repeat (high) tick();
    endtask

    initial begin
        rst = 1'b1; key_in = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mode", mode, 0);
            chk("rst_level", key_level, 1);
            chk("rst_short", press_short, 0);
            chk("rst_long", press_long, 0);
        end
        rst = 1'b0;
        clr();
        repeat (2) tick();
        chk("post_rst_level", key_level, 1);
        chk("post_rst_pulses", short_cnt + long_cnt, 0);
        key_in = 1'b1;
        repeat (10) tick();

        // Glitches of 1 and 2 samples must be filtered.
        clr();
        press(1, 10);
        press(2, 10);
        chk("glitch_level_low", lvl_low, 0);
        chk("glitch_short", short_cnt, 0);
        chk("glitch_long", long_cnt, 0);
        chk("glitch_mode", mode, 0);

        // Four short presses walk the mode through 1,2,3,0.
        exp_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            clr();
            start = cyc;
            press(6, 10);
            exp_mode = exp_mode + 2'd1;
            chk("short_cnt", short_cnt, 1);
            chk("short_long", long_cnt, 0);
            chk("short_cyc", short_cyc, start + 12);
            chk("short_mode", mode, exp_mode);
        end

        press(6, 10);
        press(6, 10);
        exp_mode = 2'd2;
        chk("pre_long_mode", mode, 2);

        // 20-cycle hold.
        clr();
        start = cyc;
        press(20, 10);
`ifdef KEY_LONG_PRESS_EN
        exp_mode = 2'd0;
        chk("long_cnt", long_cnt, 1);
        chk("long_cyc", long_cyc, start + 15);
        chk("long_no_short", short_cnt, 0);
`else
        exp_mode = 2'd3;
        chk("nolong_long", long_cnt, 0);
        chk("nolong_short", short_cnt, 1);
        chk("nolong_short_cyc", short_cyc, start + 26);
`endif
        chk("hold_mode", mode, exp_mode);

        // Disabled events are dropped, FSM keeps tracking.
        en = 1'b0;
        clr();
        press(6, 10);
        en = 1'b1;
        chk("en0_short", short_cnt, 0);
        chk("en0_long", long_cnt, 0);
        chk("en0_mode", mode, exp_mode);
        clr();
        press(6, 10);
        press(6, 10);
        exp_mode = exp_mode + 2'd2;
        chk("en1_short", short_cnt, 2);
        chk("en1_mode", mode, exp_mode);

        // Reset mid-press, quick release: press discarded.
        clr();
        key_in = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mode", mode, 0);
        chk("midrst_level", key_level, 1);
        clr();
        tick();
        key_in = 1'b1;
        repeat (12) tick();
        chk("midrst_short", short_cnt, 0);
        chk("midrst_long", long_cnt, 0);
        chk("midrst_level_low", lvl_low, 0);
        chk("midrst_mode_after", mode, 0);

        // Reset mid-press with key still low: requalified from scratch.
        press(6, 10);
        chk("scratch_pre_mode", mode, 1);
        key_in = 1'b0;
        start = cyc;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr();
        repeat (6) tick();
        key_in = 1'b1;
        repeat (10) tick();
        chk("scratch_short", short_cnt, 1);
        chk("scratch_cyc", short_cyc, start + 20);
        chk("scratch_mode", mode, 1);

        chk("never_both", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
